// File: rtl/ped_req_sched_if.sv
// -----------------------------------------------------------------------------
// ped_req_sched_if
//   Handshake bundle between the pedestrian request scheduler and the traffic
//   controller FSM.
//
//   Parameter
//     N_REQ        number of crosswalk request lines
//   Signals
//     serve_req    scheduler -> FSM : request a walk phase
//     serve_id     scheduler -> FSM : crosswalk index being requested/served
//     serve_ack    FSM -> scheduler : one-cycle accept of serve_req
//     serve_done   FSM -> scheduler : one-cycle walk-phase-finished pulse
//     pending      scheduler -> FSM : latched, not-yet-acknowledged requests
//     busy         scheduler -> FSM : scheduler is not idle
//   Modports
//     master       scheduler side
//     slave        traffic FSM side
// -----------------------------------------------------------------------------
interface ped_req_sched_if #(
   parameter int N_REQ = 2
);
   localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic             serve_req;
   logic [IDW-1:0]   serve_id;
   logic             serve_ack;
   logic             serve_done;
   logic [N_REQ-1:0] pending;
   logic             busy;

   modport master (
      output serve_req, serve_id, pending, busy,
      input  serve_ack, serve_done
   );

   modport slave (
      input  serve_req, serve_id, pending, busy,
      output serve_ack, serve_done
   );
endinterface

// File: rtl/ped_req_sched.sv
// -----------------------------------------------------------------------------
// ped_req_sched
//   Collects asynchronous pedestrian push-button requests, synchronizes (and
//   optionally debounces) them, latches them as pending and serves them one at
//   a time, round-robin, to the traffic FSM over a req/ack/done handshake.
//   A hold-off gap of HOLDOFF_CYCLES idle cycles follows every serve_done.
//
//   Parameters
//     N_REQ           number of request inputs (>=1)
//     DB_CYCLES       stable samples needed to change the debounced level (>=1)
//     HOLDOFF_CYCLES  forced idle cycles after serve_done (0 = none)
//   Ports
//     clk             system clock
//     rst_n           asynchronous active-low reset
//     btn_async       raw buttons, asynchronous to clk, active-high
//     sif             ped_req_sched_if.master (serve_req/serve_id/serve_ack/
//                     serve_done/pending/busy)
//   Build option
//     PED_DEBOUNCE_EN defined   : per-input debounce counters before the edge
//                                 detect (edge k -> pending at k+DB_CYCLES+2)
//     PED_DEBOUNCE_EN undefined : edge detect directly on the synchronizer
//                                 output (edge k -> pending at k+2)
// -----------------------------------------------------------------------------
module ped_req_sched #(
   parameter int N_REQ          = 2,
   parameter int DB_CYCLES      = 4,
   parameter int HOLDOFF_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_REQ-1:0]  btn_async,
   ped_req_sched_if.master   sif
);
   localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int HCW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

   // Elaboration-time guard on parameter legality.
   if (N_REQ < 1 || DB_CYCLES < 1 || HOLDOFF_CYCLES < 0) begin : g_bad_params
      $error("ped_req_sched: illegal parameter value");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_SERVE,
      S_HOLD
   } state_e;

   // --------------------------------------------------------------------------
   // Input path: 2-flop synchronizer, optional debounce, rising-edge detect
   // --------------------------------------------------------------------------
   logic [N_REQ-1:0] sync1_q, sync2_q;
   logic [N_REQ-1:0] lvl_prev_q, lvl_prev_d;
   logic [N_REQ-1:0] lvl;
   logic [N_REQ-1:0] rise;

`ifdef PED_DEBOUNCE_EN
   localparam int DBW = $clog2(DB_CYCLES + 1);

   logic [N_REQ-1:0] db_lvl_q, db_lvl_d;
   logic [DBW-1:0]   db_cnt_q [N_REQ];
   logic [DBW-1:0]   db_cnt_d [N_REQ];

   // The counter tracks consecutive samples that disagree with the current
   // debounced level; the level flips on the DB_CYCLES-th one.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         db_lvl_d[i] = db_lvl_q[i];
         db_cnt_d[i] = '0;
         if (sync2_q[i] != db_lvl_q[i]) begin
            if (db_cnt_q[i] == DBW'(DB_CYCLES - 1)) begin
               db_lvl_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_lvl_q <= '0;
         for (int i = 0; i < N_REQ; i++) db_cnt_q[i] <= '0;
      end else begin
         db_lvl_q <= db_lvl_d;
         for (int i = 0; i < N_REQ; i++) db_cnt_q[i] <= db_cnt_d[i];
      end
   end

   assign lvl = db_lvl_q;
`else
   assign lvl = sync2_q;
`endif

   assign lvl_prev_d = lvl;
   assign rise       = lvl & ~lvl_prev_q;

   // --------------------------------------------------------------------------
   // Scheduler state
   // --------------------------------------------------------------------------
   state_e           state_q, state_d;
   logic             serve_req_q, serve_req_d;
   logic [IDW-1:0]   serve_id_q, serve_id_d;
   logic [IDW-1:0]   last_grant_q, last_grant_d;
   logic [N_REQ-1:0] pending_q, pending_d;
   logic [HCW-1:0]   hold_q, hold_d;
   logic             busy_q, busy_d;
   logic [N_REQ-1:0] clr;

   // First set bit searching upward from last+1, wrapping modulo N_REQ.
   function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [IDW-1:0]   last);
      logic [IDW-1:0] pick;
      logic           found;
      int             idx;
      pick  = '0;
      found = 1'b0;
      for (int off = 1; off <= N_REQ; off++) begin
         idx = (int'(last) + off) % N_REQ;
         if (!found && req[idx]) begin
            pick  = IDW'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // NOTE: every always_comb output gets a default assignment first so no
   // path through the case statement can infer a latch.
   always_comb begin
      state_d      = state_q;
      serve_req_d  = serve_req_q;
      serve_id_d   = serve_id_q;
      last_grant_d = last_grant_q;
      hold_d       = hold_q;
      clr          = '0;

      unique case (state_q)
         S_IDLE: begin
            if (|pending_q) begin
               serve_id_d  = rr_pick(pending_q, last_grant_q);
               serve_req_d = 1'b1;
               state_d     = S_REQ;
            end
         end
         S_REQ: begin
            if (sif.serve_ack) begin
               clr[serve_id_q] = 1'b1;
               last_grant_d    = serve_id_q;
               serve_req_d     = 1'b0;
               state_d         = S_SERVE;
            end
         end
         S_SERVE: begin
            if (sif.serve_done) begin
               if (HOLDOFF_CYCLES > 0) begin
                  hold_d  = HCW'(HOLDOFF_CYCLES);
                  state_d = S_HOLD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_HOLD: begin
            // Leaving on the count of 1 gives exactly HOLDOFF_CYCLES in HOLD.
            hold_d = hold_q - HCW'(1);
            if (hold_q == HCW'(1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Clear first, then set: a new edge wins over an ack-clear on the same bit.
      pending_d = (pending_q & ~clr) | rise;
      busy_d    = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the synchronizer flops are reset too, so the edge detector
         // starts from a known low level and cannot fire spuriously.
         sync1_q      <= '0;
         sync2_q      <= '0;
         lvl_prev_q   <= '0;
         state_q      <= S_IDLE;
         serve_req_q  <= 1'b0;
         serve_id_q   <= '0;
         last_grant_q <= IDW'(N_REQ - 1);
         pending_q    <= '0;
         hold_q       <= '0;
         busy_q       <= 1'b0;
      end else begin
         sync1_q      <= btn_async;
         sync2_q      <= sync1_q;
         lvl_prev_q   <= lvl_prev_d;
         state_q      <= state_d;
         serve_req_q  <= serve_req_d;
         serve_id_q   <= serve_id_d;
         last_grant_q <= last_grant_d;
         pending_q    <= pending_d;
         hold_q       <= hold_d;
         busy_q       <= busy_d;
      end
   end

   assign sif.serve_req = serve_req_q;
   assign sif.serve_id  = serve_id_q;
   assign sif.pending   = pending_q;
   assign sif.busy      = busy_q;

endmodule

// File: tb/tb_ped_req_sched.sv
// -----------------------------------------------------------------------------
// tb_ped_req_sched
//   Directed bench for ped_req_sched (N_REQ=2, HOLDOFF_CYCLES=8). Expected
//   serve ids are queued when buttons are pressed and popped when the DUT
//   raises serve_req. Works in both PED_DEBOUNCE_EN builds.
// -----------------------------------------------------------------------------
module tb_ped_req_sched;
   localparam int N    = 2;
   localparam int DB   = 4;
   localparam int HOLD = 8;
`ifdef PED_DEBOUNCE_EN
   localparam int LAT   = DB + 2;
   localparam int PRESS = DB + 1;
`else
   localparam int LAT   = 2;
   localparam int PRESS = 3;
`endif

   logic         clk;
   logic         rst_n;
   logic [N-1:0] btn;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int cyc;

   ped_req_sched_if #(.N_REQ(N)) sif ();

   ped_req_sched #(
      .N_REQ          (N),
      .DB_CYCLES      (DB),
      .HOLDOFF_CYCLES (HOLD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_async (btn),
      .sif       (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_ack();
      sif.serve_ack = 1'b1;
      tick();
      sif.serve_ack = 1'b0;
   endtask

   task automatic pulse_done();
      sif.serve_done = 1'b1;
      tick();
      sif.serve_done = 1'b0;
   endtask

   // Waits (bounded) for serve_req, then scores serve_id against the queue.
   task automatic wait_grant(input string tag, output int cycles);
      cycles = 0;
      while (sif.serve_req !== 1'b1 && cycles < 100) begin
         tick();
         cycles++;
      end
      check({tag, "_seen"}, sif.serve_req, 1'b1);
      if (sif.serve_req === 1'b1) begin
         check({tag, "_sb_depth"}, exp_q.size() > 0, 1'b1);
         if (exp_q.size() > 0) check({tag, "_id"}, sif.serve_id, exp_q.pop_front());
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      btn            = '0;
      sif.serve_ack  = 1'b0;
      sif.serve_done = 1'b0;
      repeat (3) tick();
      check("rst_serve_req", sif.serve_req, 1'b0);
      check("rst_serve_id",  sif.serve_id,  1'b0);
      check("rst_pending",   sif.pending,   2'b00);
      check("rst_busy",      sif.busy,      1'b0);
      rst_n = 1'b1;
      tick();

`ifdef PED_DEBOUNCE_EN
      // Glitches shorter than DB_CYCLES never reach pending.
      for (int len = 1; len < DB; len++) begin
         btn = 2'b01;
         repeat (len) tick();
         btn = '0;
         repeat (DB + 4) tick();
         check($sformatf("glitch_%0d", len), sif.pending, 2'b00);
      end
`endif

      // Single press on button 1: exact pending latency, then grant next cycle.
      btn = 2'b10;
      exp_q.push_back(1);
      for (int e = 0; e <= LAT; e++) begin
         tick();
         if (e + 1 == PRESS) btn = '0;
         if (e == LAT - 1) check("t2_pend_early", sif.pending, 2'b00);
         if (e == LAT)     check("t2_pend",       sif.pending, 2'b10);
      end
      btn = '0;
      wait_grant("t2_grant", cyc);
      check("t2_latency", cyc, 1);
      check("t2_busy",    sif.busy, 1'b1);
      pulse_ack();
      check("t2_ack_pend", sif.pending,   2'b00);
      check("t2_ack_req",  sif.serve_req, 1'b0);
      // Stray ack in SERVE is ignored.
      pulse_ack();
      check("ack_in_serve_req",  sif.serve_req, 1'b0);
      check("ack_in_serve_busy", sif.busy,      1'b1);
      check("ack_in_serve_pend", sif.pending,   2'b00);
      pulse_done();
      repeat (HOLD - 1) tick();
      check("t2_hold_busy", sif.busy, 1'b1);
      tick();
      check("t2_idle_busy", sif.busy, 1'b0);

      // Simultaneous presses: last grant was 1, so 0 goes first, then 1.
      btn = 2'b11;
      exp_q.push_back(0);
      exp_q.push_back(1);
      repeat (PRESS) tick();
      btn = '0;
      wait_grant("t3_first", cyc);
      check("t3_pend_both", sif.pending, 2'b11);
      // Stray done in REQ is ignored.
      pulse_done();
      check("done_in_req_req",  sif.serve_req, 1'b1);
      check("done_in_req_id",   sif.serve_id,  1'b0);
      check("done_in_req_busy", sif.busy,      1'b1);
      pulse_ack();
      check("t3_ack_pend", sif.pending, 2'b10);
      // Re-press of the id under service re-latches it behind id 1.
      btn = 2'b01;
      repeat (PRESS) tick();
      btn = '0;
      repeat (LAT) tick();
      check("t3_relatch", sif.pending, 2'b11);
      exp_q.push_back(0);
      pulse_done();
      wait_grant("t3_second", cyc);
      check("t4_holdoff_a", cyc, HOLD + 1);
      pulse_ack();
      check("t3_ack2_pend", sif.pending, 2'b01);
      pulse_done();
      wait_grant("t3_third", cyc);
      check("t4_holdoff_b", cyc, HOLD + 1);

      // New edge on id 0 lands in the same cycle as the ack of id 0.
      btn = 2'b01;
      for (int e = 0; e <= LAT; e++) begin
         if (e == LAT) sif.serve_ack = 1'b1;
         tick();
         sif.serve_ack = 1'b0;
         if (e + 1 == PRESS) btn = '0;
      end
      btn = '0;
      check("collide_pend", sif.pending,   2'b01);
      check("collide_req",  sif.serve_req, 1'b0);
      exp_q.push_back(0);
      pulse_done();
      wait_grant("collide_regrant", cyc);
      check("t4_holdoff_c", cyc, HOLD + 1);
      pulse_ack();
      check("collide_clear", sif.pending, 2'b00);
      pulse_done();

      // Asynchronous reset in the middle of REQ with both bits pending.
      btn = 2'b11;
      exp_q.push_back(1);
      repeat (PRESS) tick();
      btn = '0;
      wait_grant("t1_grant", cyc);
      check("t1_pend_before", sif.pending, 2'b11);
      #1 rst_n = 1'b0;
      #1;
      check("t1_async_req",  sif.serve_req, 1'b0);
      check("t1_async_pend", sif.pending,   2'b00);
      check("t1_async_busy", sif.busy,      1'b0);
      tick();
      rst_n = 1'b1;
      repeat (20) tick();
      check("t1_after_req",  sif.serve_req, 1'b0);
      check("t1_after_pend", sif.pending,   2'b00);
      check("t1_after_busy", sif.busy,      1'b0);
      check("sb_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
